// File: rtl/isqrt_seq.sv
// Sequential 16-bit integer square root, restoring digit-by-digit, one bit per enabled cycle.
// Optional macro ISQRT_ROUND_EN selects round-to-nearest on root; remainder always refers to the floor root.
module isqrt_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [15:0] radicand,
  output logic        busy,
  output logic        done,
  output logic [7:0]  root,
  output logic [8:0]  remainder
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] rad_reg, rad_next;
  logic [7:0]  q_reg, q_next;
  logic [9:0]  rem_reg, rem_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [7:0]  root_reg, root_next;
  logic [8:0]  remainder_reg, remainder_next;

  logic [11:0] trial_rem;
  logic [11:0] trial_sub;
  logic        trial_ge;
  logic [7:0]  q_step;
  logic [9:0]  rem_step;

  // One restoring step: bring down the next radicand bit pair and try subtracting 4q+1.
  always_comb begin
    trial_rem = {rem_reg, rad_reg[15:14]};
    trial_sub = {2'b00, q_reg, 2'b01};
    trial_ge  = (trial_rem >= trial_sub);
    q_step    = {q_reg[6:0], trial_ge};
    rem_step  = 10'(trial_ge ? (trial_rem - trial_sub) : trial_rem);
  end

  always_comb begin
    state_next     = state_reg;
    rad_next       = rad_reg;
    q_next         = q_reg;
    rem_next       = rem_reg;
    cnt_next       = cnt_reg;
    root_next      = root_reg;
    remainder_next = remainder_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          rad_next   = radicand;
          q_next     = '0;
          rem_next   = '0;
          cnt_next   = '0;
        end
      end
      CALC: begin
        rad_next = {rad_reg[13:0], 2'b00};
        q_next   = q_step;
        rem_next = rem_step;
        cnt_next = cnt_reg + 3'd1;
        // Visible outputs change only on the final iteration.
        if (cnt_reg == 3'd7) begin
          state_next     = DONE;
          remainder_next = rem_step[8:0];
`ifdef ISQRT_ROUND_EN
          if ((rem_step > {2'b00, q_step}) && (q_step != 8'hFF))
            root_next = q_step + 8'd1;
          else
            root_next = q_step;
`else
          root_next = q_step;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rad_reg       <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      root_reg      <= '0;
      remainder_reg <= '0;
    end else if (ena) begin
      state_reg     <= state_next;
      rad_reg       <= rad_next;
      q_reg         <= q_next;
      rem_reg       <= rem_next;
      cnt_reg       <= cnt_next;
      root_reg      <= root_next;
      remainder_reg <= remainder_next;
    end
  end

  assign busy      = (state_reg == CALC);
  assign done      = (state_reg == DONE);
  assign root      = root_reg;
  assign remainder = remainder_reg;

endmodule

// File: doc/isqrt_seq.md
ISQRT_SEQ -- requirements
Module: isqrt_seq

Interface
REQ-001 Parameters: none; widths fixed (16-bit radicand, 8-bit root).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 ena  input  1  clock enable; when low all state, including outputs, SHALL hold.
REQ-005 start  input  1  request to begin a root computation; sampled only in IDLE with ena high.
REQ-006 radicand  input  16  unsigned operand, i.e. the x*x + y*y sum; captured on the accepting edge.
REQ-007 busy  output  1  high while state is CALC.
REQ-008 done  output  1  one-ena-cycle pulse; root and remainder valid.
REQ-009 root  output  8  unsigned floor(sqrt(radicand)), or rounded when ISQRT_ROUND_EN is defined.
REQ-010 remainder  output  9  radicand minus floor_root squared; range 0..510.

Function
REQ-011 FSM states: IDLE, CALC, DONE; all transitions occur only on clk edges with ena high.
REQ-012 IDLE -> CALC when start=1; radicand captured, working root/remainder cleared, iteration counter set to 0.
REQ-013 CALC: one digit-by-digit (non-restoring or restoring) iteration per ena cycle, MSB pair first; exactly 8 iterations.
REQ-014 CALC -> DONE on the edge completing iteration 8; root and remainder registers updated on that same edge.
REQ-015 DONE -> IDLE on the next ena edge, unconditionally; start in DONE is ignored.
REQ-016 Latency: start accepted at edge N gives done=1 after edge N+8, with ena high throughout; each ena-low cycle adds one cycle of delay.
REQ-017 start while busy or done is ignored; the captured radicand is unaffected by later changes to the radicand input.
REQ-018 root and remainder SHALL hold their last result from DONE until the final iteration of the next computation; intermediate values SHALL NOT appear on them.
REQ-019 Arithmetic is unsigned with no overflow: the internal remainder is at least 10 bits wide.
REQ-020 Boundaries: radicand 0 gives root 0 and remainder 0; radicand 65535 gives root 255 and remainder 510.
REQ-021 busy and done are never high simultaneously.

Reset
REQ-022 When rst_n=0 at a clk edge, regardless of ena: state=IDLE and busy=0, done=0, root=0, remainder=0; the counter and working registers are cleared.
REQ-023 Reset mid-CALC aborts the computation; no done pulse follows, and the first edge with rst_n=1 and start=1 starts a fresh computation.

Configuration
REQ-024 Macro ISQRT_ROUND_EN: when defined, root is round-to-nearest, i.e. floor_root+1 if remainder > floor_root, saturated at 255.
REQ-025 Without ISQRT_ROUND_EN, root is floor_root.
REQ-026 In both builds, remainder always reports radicand minus floor_root squared, and latency is unchanged.

Verification
REQ-027 Exact: radicand 144 -> root 12, rem 0; radicand 200 -> root 14, rem 4; done exactly 8 cycles after the start edge.
REQ-028 Extremes: radicand 0 -> root 0, rem 0; radicand 65535 -> root 255, rem 510 (also 255 with ISQRT_ROUND_EN, saturated).
REQ-029 Rounding (ISQRT_ROUND_EN): radicand 210 -> root 14, rem 14; radicand 211 -> root 15, rem 15. Without the macro, radicand 211 -> root 14.
REQ-030 Stall: ena low for 3 cycles mid-CALC -> done after edge N+11, correct result, outputs frozen while ena low.
REQ-031 Protocol and reset: start pulsed with radicand 9 during busy -> ignored, first result unchanged. rst_n low at iteration 4 -> outputs 0, no done; a new start with 81 -> root 9, rem 0.
